// File: rtl/enc_tx_pkg.sv
// Shared symbol codes and scheduler state encoding for the 8B/10B transmit scheduler.
package enc_tx_pkg;

   localparam logic [7:0] K28_5   = 8'hBC;
   localparam logic [7:0] K_SOF   = 8'hFB;
   localparam logic [7:0] K_EOF   = 8'hFD;
   localparam logic [7:0] K_FILL  = 8'hF7;
   localparam logic [7:0] K_ABORT = 8'hFE;

   typedef enum logic [2:0] {
      ST_ALIGN,
      ST_IDLE,
      ST_SOF,
      ST_CHID,
      ST_DATA,
      ST_EOF,
      ST_ABORT
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. Combinational; the parent latches the grant at SOF.
module rr_arb2 (
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic last_grant_i,
   output logic grant_o,
   output logic any_o
);

   // On contention the requester that did not win last time goes next.
   always_comb begin
      any_o   = valid0_i | valid1_i;
      grant_o = (valid0_i & valid1_i) ? ~last_grant_i : valid1_i;
   end

endmodule

// File: rtl/enc_tx_scheduler.sv
// Transmit-side sequencer feeding the 8B/10B encoder one symbol per BYTECLK:
// comma alignment burst, K28.5 idle fill, SOF/EOF framing of two requesters.
// Optional channel-ID byte after SOF is built when ENC_TX_CHID_EN is defined.
//
// state    | meaning
// ALIGN    | sending K28.5 alignment burst, counting while link_en is high
// IDLE     | K28.5 fill, counting inter-frame gap, arbitrating for next SOF
// SOF      | reserved; SOF is emitted on the IDLE exit edge
// CHID     | channel-ID data byte {7'b0,grant} (ENC_TX_CHID_EN only)
// DATA     | forwarding granted requester's bytes, F7 fill when it stalls
// EOF      | closing the frame with K29.7
// ABORT    | reserved; the abort symbol is emitted on the exit edge to ALIGN
module enc_tx_scheduler
   import enc_tx_pkg::*;
#(
   parameter int ALIGN_LEN = 4,
   parameter int IFG_MIN   = 2
) (
   input  logic       BYTECLK,
   input  logic       rst_n,
   input  logic       link_en,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] enc_data,
   output logic       enc_k,
   output logic       align_done,
   output logic       busy
);

   localparam int ACNT_W = $clog2(ALIGN_LEN + 1);
   localparam int GAP_W  = $clog2(IFG_MIN + 1);
   localparam logic [ACNT_W-1:0] ACNT_END = ACNT_W'(ALIGN_LEN);
   localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(IFG_MIN);

   state_e            state_q, state_d;
   logic [ACNT_W-1:0] align_cnt_q, align_cnt_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              align_done_q, align_done_d;
   logic              grant_q, grant_d;
   logic              last_grant_q, last_grant_d;
   logic [7:0]        enc_data_q, enc_data_d;
   logic              enc_k_q, enc_k_d;

   logic              arb_grant, arb_any;
   logic              sel_valid, sel_last;
   logic [7:0]        sel_data;

   rr_arb2 u_arb (
      .valid0_i     (req0_valid),
      .valid1_i     (req1_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (arb_grant),
      .any_o        (arb_any)
   );

   // Granted requester's byte stream and handshake; ready only while forwarding.
   always_comb begin
      sel_valid  = grant_q ? req1_valid : req0_valid;
      sel_data   = grant_q ? req1_data  : req0_data;
      sel_last   = grant_q ? req1_last  : req0_last;
      req0_ready = (state_q == ST_DATA) && link_en && !grant_q;
      req1_ready = (state_q == ST_DATA) && link_en &&  grant_q;
      busy       = (state_q == ST_SOF) || (state_q == ST_CHID) ||
                   (state_q == ST_DATA) || (state_q == ST_EOF);
   end

   // Next state and next symbol; the symbol register loads on every edge.
   always_comb begin
      state_d      = state_q;
      align_cnt_d  = align_cnt_q;
      gap_d        = gap_q;
      align_done_d = align_done_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      enc_data_d   = K28_5;
      enc_k_d      = 1'b1;
      if (!link_en) begin
         // A frame in flight is terminated with one abort symbol.
         if (busy) begin
            enc_data_d = K_ABORT;
         end
         state_d      = ST_ALIGN;
         align_cnt_d  = '0;
         align_done_d = 1'b0;
      end else begin
         case (state_q)
            ST_ALIGN: begin
               if (align_cnt_q == ACNT_END) begin
                  state_d      = ST_IDLE;
                  align_done_d = 1'b1;
                  gap_d        = GAP_END;
               end else begin
                  align_cnt_d = align_cnt_q + 1'b1;
               end
            end
            ST_IDLE: begin
               if (gap_q >= GAP_END && arb_any) begin
                  grant_d    = arb_grant;
                  enc_data_d = K_SOF;
`ifdef ENC_TX_CHID_EN
                  state_d    = ST_CHID;
`else
                  state_d    = ST_DATA;
`endif
               end else if (gap_q < GAP_END) begin
                  gap_d = gap_q + 1'b1;
               end
            end
`ifdef ENC_TX_CHID_EN
            ST_CHID: begin
               enc_data_d = {7'b0, grant_q};
               enc_k_d    = 1'b0;
               state_d    = ST_DATA;
            end
`endif
            ST_DATA: begin
               if (sel_valid) begin
                  enc_data_d = sel_data;
                  enc_k_d    = 1'b0;
                  if (sel_last) begin
                     state_d = ST_EOF;
                  end
               end else begin
                  enc_data_d = K_FILL;
               end
            end
            ST_EOF: begin
               enc_data_d   = K_EOF;
               last_grant_d = grant_q;
               gap_d        = '0;
               state_d      = ST_IDLE;
            end
            default: begin
               state_d      = ST_ALIGN;
               align_cnt_d  = '0;
               align_done_d = 1'b0;
            end
         endcase
      end
   end

   // State, counters and the registered encoder interface.
   always_ff @(posedge BYTECLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_ALIGN;
         align_cnt_q  <= '0;
         gap_q        <= GAP_END;
         align_done_q <= 1'b0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         enc_data_q   <= K28_5;
         enc_k_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         align_cnt_q  <= align_cnt_d;
         gap_q        <= gap_d;
         align_done_q <= align_done_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         enc_data_q   <= enc_data_d;
         enc_k_q      <= enc_k_d;
      end
   end

   assign enc_data   = enc_data_q;
   assign enc_k      = enc_k_q;
   assign align_done = align_done_q;

endmodule

// File: tb/tb_enc_tx_scheduler.sv
// Directed scoreboard bench for enc_tx_scheduler (default parameters).
module tb_enc_tx_scheduler;

   logic       BYTECLK = 1'b0;
   logic       rst_n;
   logic       link_en;
   logic       req0_valid, req0_last, req0_ready;
   logic [7:0] req0_data;
   logic       req1_valid, req1_last, req1_ready;
   logic [7:0] req1_data;
   logic [7:0] enc_data;
   logic       enc_k, align_done, busy;

   int         n_vec = 0;
   int         n_err = 0;
   logic [8:0] exp_q[$];

   enc_tx_scheduler dut (
      .BYTECLK    (BYTECLK),
      .rst_n      (rst_n),
      .link_en    (link_en),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_last  (req0_last),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_last  (req1_last),
      .req1_ready (req1_ready),
      .enc_data   (enc_data),
      .enc_k      (enc_k),
      .align_done (align_done),
      .busy       (busy)
   );

   always #5 BYTECLK = ~BYTECLK;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed k,data=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs are already set; check readys, queue the expected symbol, clock, compare.
   task automatic step(input string tag, input logic r0, input logic r1,
                       input logic [7:0] d, input logic k);
      logic [8:0] got;
      #1;
      chk1({tag, "/rdy0"}, req0_ready, r0);
      chk1({tag, "/rdy1"}, req1_ready, r1);
      exp_q.push_back({k, d});
      @(posedge BYTECLK);
      #1;
      got = exp_q.pop_front();
      chk9({tag, "/sym"}, {enc_k, enc_data}, got);
   endtask

   task automatic set0(input logic v, input logic [7:0] d, input logic l);
      req0_valid = v; req0_data = d; req0_last = l;
   endtask

   task automatic set1(input logic v, input logic [7:0] d, input logic l);
      req1_valid = v; req1_data = d; req1_last = l;
   endtask

   initial begin
      rst_n   = 1'b0;
      link_en = 1'b1;
      set0(1'b0, 8'h00, 1'b0);
      set1(1'b0, 8'h00, 1'b0);
      #12;
      chk9("reset/sym", {enc_k, enc_data}, 9'h1BC);
      chk1("reset/align_done", align_done, 1'b0);
      chk1("reset/busy", busy, 1'b0);
      chk1("reset/rdy0", req0_ready, 1'b0);
      chk1("reset/rdy1", req1_ready, 1'b0);
      rst_n = 1'b1;

      // Alignment burst: four counted BC, align_done rises on the fifth edge.
      for (int i = 0; i < 4; i++) begin
         step("align", 1'b0, 1'b0, 8'hBC, 1'b1);
         chk1("align/done_low", align_done, 1'b0);
      end
      step("align5", 1'b0, 1'b0, 8'hBC, 1'b1);
      chk1("align/done_high", align_done, 1'b1);
      step("idle", 1'b0, 1'b0, 8'hBC, 1'b1);
      step("idle", 1'b0, 1'b0, 8'hBC, 1'b1);
      chk1("idle/busy", busy, 1'b0);

      // req0 packet 11,22,33.
      set0(1'b1, 8'h11, 1'b0);
      step("p0/sof", 1'b0, 1'b0, 8'hFB, 1'b1);
      chk1("p0/busy", busy, 1'b1);
      step("p0/d11", 1'b1, 1'b0, 8'h11, 1'b0);
      set0(1'b1, 8'h22, 1'b0);
      step("p0/d22", 1'b1, 1'b0, 8'h22, 1'b0);
      set0(1'b1, 8'h33, 1'b1);
      step("p0/d33", 1'b1, 1'b0, 8'h33, 1'b0);
      set0(1'b0, 8'h00, 1'b0);
      step("p0/eof", 1'b0, 1'b0, 8'hFD, 1'b1);
      step("p0/gap", 1'b0, 1'b0, 8'hBC, 1'b1);
      step("p0/gap", 1'b0, 1'b0, 8'hBC, 1'b1);

      // Both always valid, single-byte packets: grants alternate (last winner was 0).
      set0(1'b1, 8'hA0, 1'b1);
      set1(1'b1, 8'hB1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         logic g;
         g = (i % 2 == 0);
         step("rr/sof", 1'b0, 1'b0, 8'hFB, 1'b1);
         step("rr/data", !g, g, g ? 8'hB1 : 8'hA0, 1'b0);
         if (i == 3) begin
            set0(1'b0, 8'h00, 1'b0);
            set1(1'b0, 8'h00, 1'b0);
         end
         step("rr/eof", 1'b0, 1'b0, 8'hFD, 1'b1);
         step("rr/gap", 1'b0, 1'b0, 8'hBC, 1'b1);
         step("rr/gap", 1'b0, 1'b0, 8'hBC, 1'b1);
      end

      // req0 stalls for two cycles mid-packet.
      set0(1'b1, 8'h44, 1'b0);
      step("fill/sof", 1'b0, 1'b0, 8'hFB, 1'b1);
      step("fill/d44", 1'b1, 1'b0, 8'h44, 1'b0);
      set0(1'b0, 8'h00, 1'b0);
      step("fill/f7a", 1'b1, 1'b0, 8'hF7, 1'b1);
      step("fill/f7b", 1'b1, 1'b0, 8'hF7, 1'b1);
      set0(1'b1, 8'h55, 1'b0);
      step("fill/d55", 1'b1, 1'b0, 8'h55, 1'b0);
      set0(1'b1, 8'h66, 1'b1);
      step("fill/d66", 1'b1, 1'b0, 8'h66, 1'b0);
      set0(1'b0, 8'h00, 1'b0);
      step("fill/eof", 1'b0, 1'b0, 8'hFD, 1'b1);
      step("fill/gap", 1'b0, 1'b0, 8'hBC, 1'b1);
      step("fill/gap", 1'b0, 1'b0, 8'hBC, 1'b1);

      // Payload byte equal to K28.5 goes out as data.
      set1(1'b1, 8'hBC, 1'b1);
      step("kdat/sof", 1'b0, 1'b0, 8'hFB, 1'b1);
`ifdef ENC_TX_CHID_EN
      step("kdat/chid", 1'b0, 1'b0, 8'h01, 1'b0);
`endif
      step("kdat/bc", 1'b0, 1'b1, 8'hBC, 1'b0);
      set1(1'b0, 8'h00, 1'b0);
      step("kdat/eof", 1'b0, 1'b0, 8'hFD, 1'b1);
      step("kdat/gap", 1'b0, 1'b0, 8'hBC, 1'b1);
      step("kdat/gap", 1'b0, 1'b0, 8'hBC, 1'b1);

      // link_en drop during DATA: one abort, byte presented then is not consumed.
      set0(1'b1, 8'h77, 1'b0);
      step("abt/sof", 1'b0, 1'b0, 8'hFB, 1'b1);
      step("abt/d77", 1'b1, 1'b0, 8'h77, 1'b0);
      set0(1'b1, 8'h88, 1'b1);
      link_en = 1'b0;
      step("abt/fe", 1'b0, 1'b0, 8'hFE, 1'b1);
      chk1("abt/done", align_done, 1'b0);
      chk1("abt/busy", busy, 1'b0);
      step("abt/bc", 1'b0, 1'b0, 8'hBC, 1'b1);
      link_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step("realign", 1'b0, 1'b0, 8'hBC, 1'b1);
         chk1("realign/done_low", align_done, 1'b0);
      end
      step("realign5", 1'b0, 1'b0, 8'hBC, 1'b1);
      chk1("realign/done_high", align_done, 1'b1);
      step("abt/sof2", 1'b0, 1'b0, 8'hFB, 1'b1);
      step("abt/d88", 1'b1, 1'b0, 8'h88, 1'b0);
      set0(1'b0, 8'h00, 1'b0);
      step("abt/eof", 1'b0, 1'b0, 8'hFD, 1'b1);
      step("abt/gap", 1'b0, 1'b0, 8'hBC, 1'b1);
      step("abt/gap", 1'b0, 1'b0, 8'hBC, 1'b1);

      // Asynchronous reset mid-packet: outputs return to reset values at once.
      set1(1'b1, 8'h99, 1'b0);
      step("rst/sof", 1'b0, 1'b0, 8'hFB, 1'b1);
      step("rst/d99", 1'b0, 1'b1, 8'h99, 1'b0);
      rst_n = 1'b0;
      #1;
      chk9("rst/sym", {enc_k, enc_data}, 9'h1BC);
      chk1("rst/done", align_done, 1'b0);
      chk1("rst/busy", busy, 1'b0);
      chk1("rst/rdy1", req1_ready, 1'b0);
      set1(1'b0, 8'h00, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step("rst/align", 1'b0, 1'b0, 8'hBC, 1'b1);
      end
      chk1("rst/realigned", align_done, 1'b1);
      // last_grant returns to 1, so requester 0 wins the first contention.
      set0(1'b1, 8'hC0, 1'b1);
      set1(1'b1, 8'hC1, 1'b1);
      step("rst/sof2", 1'b0, 1'b0, 8'hFB, 1'b1);
      step("rst/first", 1'b1, 1'b0, 8'hC0, 1'b0);
      set0(1'b0, 8'h00, 1'b0);
      set1(1'b0, 8'h00, 1'b0);
      step("rst/eof", 1'b0, 1'b0, 8'hFD, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
